// File: rtl/eth_parser_pkg.sv
// Shared Ethernet parser types: the per-frame metadata word and egress FIFO defaults.
// Pure declarations; no latency or flow control of its own.
package eth_parser_pkg;

   typedef struct packed {
      logic [47:0] dest_mac;
      logic [47:0] src_mac;
      logic [11:0] vlan_id;
      logic        is_vlan;
      logic        is_ipv4;
      logic        is_ipv6;
      logic        is_arp;
      logic        is_unknown;
   } eth_metadata_t;

   localparam int META_W                  = $bits(eth_metadata_t);
   localparam int META_FIFO_DEPTH_DEFAULT = 4;
   localparam int META_CNT_W_DEFAULT      = 16;

   function automatic logic meta_is_unknown(input eth_metadata_t m);
      return m.is_unknown;
   endfunction

endpackage

// File: rtl/meta_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO; a word pushed on one edge is readable the next cycle.
// No internal protection: the caller must only pop when non-empty and only push when not full or popping.
module meta_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Storage is deliberately not reset; empty masks stale contents on the read port.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/metadata_egress_fifo.sv
// Egress buffer for metadata words: FWFT, one-cycle write-to-read latency; input has no backpressure, so
// words arriving while full (and not popped) are dropped and counted. Define METADATA_UNKNOWN_FILTER_EN to discard is_unknown words.
module metadata_egress_fifo
   import eth_parser_pkg::*;
#(
   parameter int DEPTH = META_FIFO_DEPTH_DEFAULT,
   parameter int CNT_W = META_CNT_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [META_W-1:0]        in_metadata,
   input  logic                     in_valid,
   output logic [META_W-1:0]        out_metadata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_count,
   output logic [CNT_W-1:0]         accept_count
`ifdef METADATA_UNKNOWN_FILTER_EN
   ,
   output logic [CNT_W-1:0]         filter_count
`endif
);

   logic fifo_full;
   logic fifo_empty;
   logic pop;
   logic push;
   logic drop;
   logic filtered;

`ifdef METADATA_UNKNOWN_FILTER_EN
   assign filtered = in_valid && meta_is_unknown(eth_metadata_t'(in_metadata));
`else
   assign filtered = 1'b0;
`endif

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the incoming word.
   assign push      = in_valid && !filtered && (!fifo_full || pop);
   assign drop      = in_valid && !filtered && fifo_full && !pop;

   meta_sync_fifo #(
      .WIDTH (META_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_metadata),
      .pop       (pop),
      .rd_data   (out_metadata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow     <= 1'b0;
         drop_count   <= '0;
         accept_count <= '0;
      end else begin
         overflow <= drop;
         if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
         end
         if (push && (accept_count != '1)) begin
            accept_count <= accept_count + CNT_W'(1);
         end
      end
   end

`ifdef METADATA_UNKNOWN_FILTER_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         filter_count <= '0;
      end else if (filtered && (filter_count != '1)) begin
         filter_count <= filter_count + CNT_W'(1);
      end
   end
`endif

endmodule
